// File: rtl/bin_to_bcd_3digit.sv
// Sequential double-dabble converter: 10-bit binary to three zero-extended BCD digits.
// A conversion takes 10 shift cycles after the accepting edge; outputs hold between runs.
module bin_to_bcd_3digit #(
  parameter bit SATURATE = 1'b1
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_Start,
  input  logic [9:0] i_Value,
  output logic       o_Busy,
  output logic       o_Valid,
  output logic       o_Overflow,
  output logic [6:0] o_SegOne,
  output logic [6:0] o_SegTwo,
  output logic [6:0] o_SegThree
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_CONV = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [21:0] shift_q, shift_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ovf_pend_q, ovf_pend_d;
  logic [3:0]  one_q, one_d, ten_q, ten_d, hun_q, hun_d;
  logic        ovf_q, ovf_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic [21:0] adj_s, shl_s;
  logic [9:0]  load_val_s;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  // Load value: clamp to 999 when saturating, otherwise pass through (mod 1000 falls out of the shifts)
  always_comb begin
    if (SATURATE && (i_Value > 10'd999)) begin
      load_val_s = 10'd999;
    end else begin
      load_val_s = i_Value;
    end
  end

  // Add-3 correction on pre-shift nibbles, then shift; bit 21 (thousands carry) falls off
  always_comb begin
    adj_s        = shift_q;
    adj_s[13:10] = add3(shift_q[13:10]);
    adj_s[17:14] = add3(shift_q[17:14]);
    adj_s[21:18] = add3(shift_q[21:18]);
    shl_s        = {adj_s[20:0], 1'b0};
  end

  // Next-state and output-register logic
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    one_d      = one_q;
    ten_d      = ten_q;
    hun_d      = hun_q;
    ovf_d      = ovf_q;
    valid_d    = 1'b0;
    busy_d     = busy_q;
    case (state_q)
      S_IDLE: begin
        if (i_Start) begin
          shift_d    = {12'd0, load_val_s};
          ovf_pend_d = (i_Value > 10'd999);
          cnt_d      = 4'd0;
          state_d    = S_CONV;
          busy_d     = 1'b1;
        end else begin
          busy_d     = 1'b0;
        end
      end
      S_CONV: begin
        shift_d = shl_s;
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == 4'd9) begin
          one_d   = shl_s[13:10];
          ten_d   = shl_s[17:14];
          hun_d   = shl_s[21:18];
          ovf_d   = ovf_pend_q;
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any conversion in flight
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q    <= S_IDLE;
      shift_q    <= 22'd0;
      cnt_q      <= 4'd0;
      ovf_pend_q <= 1'b0;
      one_q      <= 4'd0;
      ten_q      <= 4'd0;
      hun_q      <= 4'd0;
      ovf_q      <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      one_q      <= one_d;
      ten_q      <= ten_d;
      hun_q      <= hun_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  assign o_Busy     = busy_q;
  assign o_Valid    = valid_q;
  assign o_Overflow = ovf_q;
  assign o_SegOne   = {3'b000, one_q};
  assign o_SegTwo   = {3'b000, ten_q};
  assign o_SegThree = {3'b000, hun_q};

endmodule

// File: tb/tb_bin_to_bcd_3digit.sv
// Self-checking bench: one saturating and one modulo instance share stimulus and are
// compared against a decimal-arithmetic reference model.
module tb_bin_to_bcd_3digit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [9:0] value = 10'd0;

  logic       a_busy, a_valid, a_ovf, b_busy, b_valid, b_ovf;
  logic [6:0] a_s1, a_s2, a_s3, b_s1, b_s2, b_s3;

  int tests = 0;
  int fails = 0;

  int          lat_g, busy_g;
  logic [21:0] obs_a, obs_b;
  logic        after_valid_g;

  always #5 clk = ~clk;

  bin_to_bcd_3digit #(.SATURATE(1'b1)) dut_sat (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start), .i_Value(value),
    .o_Busy(a_busy), .o_Valid(a_valid), .o_Overflow(a_ovf),
    .o_SegOne(a_s1), .o_SegTwo(a_s2), .o_SegThree(a_s3)
  );

  bin_to_bcd_3digit #(.SATURATE(1'b0)) dut_mod (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Start(start), .i_Value(value),
    .o_Busy(b_busy), .o_Valid(b_valid), .o_Overflow(b_ovf),
    .o_SegOne(b_s1), .o_SegTwo(b_s2), .o_SegThree(b_s3)
  );

  // Reference: {overflow, hundreds, tens, ones} with each digit as a 7-bit field
  function automatic logic [21:0] model(input int v, input bit sat);
    int   d;
    logic ovf;
    ovf = (v > 999);
    d   = ovf ? (sat ? 999 : v % 1000) : v;
    return {ovf, 7'(d / 100), 7'((d / 10) % 10), 7'(d % 10)};
  endfunction

  // Drives one start and waits (bounded) for the completion pulse; captures observations
  task automatic run_conv(input logic [9:0] v);
    @(negedge clk); start = 1'b1; value = v;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    lat_g  = 0;
    busy_g = a_busy ? 1 : 0;
    while (!a_valid && lat_g < 20) begin
      @(posedge clk); lat_g++;
      @(negedge clk);
      if (a_busy) busy_g++;
    end
    obs_a = {a_ovf, a_s3, a_s2, a_s1};
    obs_b = {b_ovf, b_s3, b_s2, b_s1};
    @(negedge clk);
    after_valid_g = a_valid | b_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({a_busy, a_valid, a_ovf, a_s3, a_s2, a_s1} !== 24'd0) begin
      fails++; $display("FAIL reset_sat: got %h want 0", {a_busy, a_valid, a_ovf, a_s3, a_s2, a_s1});
    end
    tests++;
    if ({b_busy, b_valid, b_ovf, b_s3, b_s2, b_s1} !== 24'd0) begin
      fails++; $display("FAIL reset_mod: got %h want 0", {b_busy, b_valid, b_ovf, b_s3, b_s2, b_s1});
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if ({a_busy, a_valid, b_busy, b_valid} !== 4'd0) begin
      fails++; $display("FAIL post_reset_idle: got %b want 0000", {a_busy, a_valid, b_busy, b_valid});
    end
  endtask

  task automatic test_zero();
    run_conv(10'd0);
    tests++;
    if (lat_g !== 10) begin fails++; $display("FAIL zero_latency: got %0d want 10", lat_g); end
    tests++;
    if (busy_g !== 10) begin fails++; $display("FAIL zero_busy_cycles: got %0d want 10", busy_g); end
    tests++;
    if (obs_a !== model(0, 1'b1)) begin fails++; $display("FAIL zero_digits: got %h want %h", obs_a, model(0, 1'b1)); end
    tests++;
    if (after_valid_g !== 1'b0) begin fails++; $display("FAIL zero_valid_one_cycle: got %b want 0", after_valid_g); end
  endtask

  task automatic test_values();
    int vals[6] = '{999, 507, 10, 1023, 42, 1000};
    foreach (vals[i]) begin
      run_conv(10'(vals[i]));
      tests++;
      if (obs_a !== model(vals[i], 1'b1)) begin
        fails++; $display("FAIL value_sat v=%0d: got %h want %h", vals[i], obs_a, model(vals[i], 1'b1));
      end
      tests++;
      if (obs_b !== model(vals[i], 1'b0)) begin
        fails++; $display("FAIL value_mod v=%0d: got %h want %h", vals[i], obs_b, model(vals[i], 1'b0));
      end
      tests++;
      if (lat_g !== 10 || after_valid_g !== 1'b0) begin
        fails++; $display("FAIL value_timing v=%0d: got lat %0d after %b want 10/0", vals[i], lat_g, after_valid_g);
      end
    end
  endtask

  task automatic test_ignore_start();
    int pulses = 0;
    @(negedge clk); start = 1'b1; value = 10'd123;
    @(posedge clk);
    @(negedge clk); start = 1'b0; value = 10'd456;
    for (int e = 1; e <= 21; e++) begin
      start = (e == 3 || e == 10 || e == 11);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      if (a_valid) pulses++;
      if (e == 10) begin
        tests++;
        if (a_valid !== 1'b1 || {a_ovf, a_s3, a_s2, a_s1} !== model(123, 1'b1)) begin
          fails++; $display("FAIL ignore_first: got v=%b %h want 1 %h", a_valid, {a_ovf, a_s3, a_s2, a_s1}, model(123, 1'b1));
        end
      end
      if (e == 21) begin
        tests++;
        if (a_valid !== 1'b1 || {b_ovf, b_s3, b_s2, b_s1} !== model(456, 1'b0)) begin
          fails++; $display("FAIL ignore_second: got v=%b %h want 1 %h", a_valid, {b_ovf, b_s3, b_s2, b_s1}, model(456, 1'b0));
        end
      end
    end
    tests++;
    if (pulses !== 2) begin fails++; $display("FAIL ignore_pulse_count: got %0d want 2", pulses); end
  endtask

  task automatic test_back_to_back();
    int v1, v2, pulses;
    pulses = 0;
    v1 = $urandom_range(0, 1023);
    v2 = $urandom_range(0, 1023);
    @(negedge clk); start = 1'b1; value = 10'(v1);
    @(posedge clk);
    @(negedge clk); value = 10'(v2);
    for (int e = 1; e <= 21; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (a_valid) pulses++;
      if (e == 10) begin
        tests++;
        if ({a_ovf, a_s3, a_s2, a_s1} !== model(v1, 1'b1) || {b_ovf, b_s3, b_s2, b_s1} !== model(v1, 1'b0)) begin
          fails++; $display("FAIL b2b_first v=%0d: got %h/%h want %h/%h", v1, {a_ovf, a_s3, a_s2, a_s1},
                            {b_ovf, b_s3, b_s2, b_s1}, model(v1, 1'b1), model(v1, 1'b0));
        end
      end
      if (e == 21) begin
        tests++;
        if (a_valid !== 1'b1 || {a_ovf, a_s3, a_s2, a_s1} !== model(v2, 1'b1) || {b_ovf, b_s3, b_s2, b_s1} !== model(v2, 1'b0)) begin
          fails++; $display("FAIL b2b_second v=%0d: got %b %h/%h want 1 %h/%h", v2, a_valid, {a_ovf, a_s3, a_s2, a_s1},
                            {b_ovf, b_s3, b_s2, b_s1}, model(v2, 1'b1), model(v2, 1'b0));
        end
      end
    end
    start = 1'b0;
    tests++;
    if (pulses !== 2) begin fails++; $display("FAIL b2b_pulse_count: got %0d want 2", pulses); end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int pulses = 0;
    run_conv(10'd7);
    @(negedge clk); start = 1'b1; value = 10'd888;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if ({a_busy, a_valid, a_ovf, a_s3, a_s2, a_s1, b_busy, b_s1} !== 31'd0) begin
      fails++; $display("FAIL abort_outputs: got %h want 0", {a_busy, a_valid, a_ovf, a_s3, a_s2, a_s1, b_busy, b_s1});
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (a_valid || b_valid || a_busy) pulses++;
    end
    tests++;
    if (pulses !== 0) begin fails++; $display("FAIL abort_no_valid: got %0d want 0", pulses); end
    run_conv(10'd888);
    tests++;
    if (obs_a !== model(888, 1'b1) || lat_g !== 10) begin
      fails++; $display("FAIL abort_reconvert: got %h lat %0d want %h lat 10", obs_a, lat_g, model(888, 1'b1));
    end
  endtask

  task automatic test_random();
    int v;
    for (int i = 0; i < 40; i++) begin
      v = $urandom_range(0, 1023);
      run_conv(10'(v));
      tests++;
      if (obs_a !== model(v, 1'b1) || obs_b !== model(v, 1'b0) || lat_g !== 10) begin
        fails++; $display("FAIL random v=%0d: got %h/%h lat %0d want %h/%h lat 10", v, obs_a, obs_b, lat_g,
                          model(v, 1'b1), model(v, 1'b0));
      end
    end
  endtask

  task automatic test_sweep();
    for (int v = 0; v < 1024; v++) begin
      run_conv(10'(v));
      tests++;
      if (obs_a !== model(v, 1'b1) || obs_b !== model(v, 1'b0)) begin
        fails++; $display("FAIL sweep v=%0d: got %h/%h want %h/%h", v, obs_a, obs_b, model(v, 1'b1), model(v, 1'b0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_values();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_random();
    test_sweep();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
